detect_burst_paged: RTL and testbench
=====================================

# detect_burst_paged

Parametrised successor of the address-stream burst detector in the memory-mapped port path. It sits between a kernel's per-beat address FIFO and the AXI request generator, and merges consecutive beat addresses into bursts. Each burst is emitted as one {length, base address} token on the address FIFO. The same length is fanned out to a configurable number of length FIFOs. Compared with the previous generation it adds three behaviours: bursts never cross a page (AXI 4 KB) boundary, an explicit flush input, and a running burst counter.

## Interface
- AddrWidth, 64, byte address width
- DataWidthBytesLog, 6, log2 bytes per beat; beat index = addr[AddrWidth-1:DataWidthBytesLog]
- PageBytesLog, 12, log2 page size; must satisfy DataWidthBytesLog < PageBytesLog < AddrWidth
- WaitTimeWidth, 4, width of idle-timeout counter
- BurstLenWidth, 8, width of length field (beats minus one)
- NumLenPorts, 2, number of length output FIFOs (>=1)
- CountWidth, 32, width of burst_count
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- max_wait_time  in  WaitTimeWidth  idle cycles tolerated before a pending burst is emitted
- max_burst_len  in  BurstLenWidth  maximum length field; 0 disables merging
- flush  in  1  force emission of the pending burst
- addr_dout  in  AddrWidth  input address
- addr_empty_n  in  1  input valid
- addr_read  out  1  input pop
- addr_din  out  BurstLenWidth+AddrWidth  {burst_len, base_addr}
- addr_full_n  in  1  address FIFO not full
- addr_write  out  1  address FIFO push
- burst_len_din  out  NumLenPorts*BurstLenWidth  length per port, port i at slice [i*BurstLenWidth +: BurstLenWidth]
- burst_len_full_n  in  NumLenPorts  per-port not full
- burst_len_write  out  NumLenPorts  per-port push; all bits identical
- burst_count  out  CountWidth  number of bursts emitted since reset

## Operation
- State: base_addr, base_valid, burst_len, wait_time, burst_count. All reset asynchronously to 0 when rst_n=0.
- ready = addr_full_n AND all bits of burst_len_full_n.
- addr_read = ready AND addr_empty_n. This is combinational; an address is accepted in the same cycle.
- Outputs: addr_din = {burst_len, base_addr}. Every burst_len_din slice = burst_len. addr_write = burst_len_write[i] = emit, where emit is combinational.
- If ready=0: no accept, no emit, and all state holds. This includes wait_time and flush, which is ignored.
- **Accept, base_valid=0:** base_addr<=a, base_valid<=1, burst_len<=0, wait_time<=0.
- **Accept, base_valid=1, merge case.** Merge when all of the following hold:
  - beat(a) == beat(base_addr)+burst_len+1, computed in AddrWidth-DataWidthBytesLog bits with no wrap allowance;
  - burst_len < max_burst_len;
  - a[AddrWidth-1:PageBytesLog] == base_addr[AddrWidth-1:PageBytesLog];
  - flush=0.
  
  On merge: burst_len<=burst_len+1, wait_time<=0.
- **Accept, base_valid=1, otherwise:** emit=1. Then base_addr<=a, burst_len<=0, base_valid stays 1, wait_time<=0.
- **No accept, base_valid=1, flush=1:** emit=1, base_valid<=0, burst_len<=0, wait_time<=0.
- **No accept, base_valid=1, flush=0:**
  - If wait_time < max_wait_time: wait_time++.
  - Otherwise: emit=1, base_valid<=0, burst_len<=0, wait_time<=0.
- **No accept, base_valid=0:** idle. flush has no effect.
- burst_count increments by 1 on every emit and wraps modulo 2^CountWidth.
- Low address bits within a beat are carried in base_addr unchanged and are ignored for the contiguity check.

## Timing
- Accept-to-emit latency is at least 1 cycle. A burst is emitted either in the cycle the breaking address is accepted, or max_wait_time+1 idle cycles after its last beat. With max_wait_time=0, that is 1 idle cycle.
- Emit and accept can occur in the same cycle. The emitted token is the pre-accept state.
- emit is never asserted while ready=0, so no FIFO is ever written while full.
- Reset mid-burst discards the pending burst; nothing is emitted.
- Reset values of outputs:
  - addr_read=0, addr_write=0, burst_len_write=0;
  - addr_din=0, burst_len_din=0, burst_count=0.
  - addr_read is the exception during reset: it follows addr_empty_n AND ready combinationally. The bench holds addr_empty_n=0 during reset.

## Test plan
- Input 0x0, 0x40, 0x80, 0xC0 back-to-back, then idle, with max_burst_len=255 and max_wait_time=3 -> exactly one emit, addr_din={3, 0x0}, 4 idle cycles after the last accept; burst_count=1.
- Input 0xF80, 0xFC0, 0x1000, 0x1040, then idle -> two emits: {1, 0xF80} in the cycle 0x1000 is accepted, then {1, 0x1000} after the timeout.
- max_burst_len=1, input 0x0, 0x40, 0x80 -> {1, 0x0} emitted on the accept of 0x80, then {0, 0x80} on timeout. With max_burst_len=0, the same input produces three length-0 bursts.
- Pending burst {2, 0x100}, then burst_len_full_n[1]=0 for 10 cycles -> addr_read=0 and no write throughout, state held. After release, normal timeout emission.
- flush=1 pulsed while {1, 0x200} is pending with no input -> emitted the same cycle. flush=1 together with accept of 0x240 -> {1, 0x200} emitted, and 0x240 becomes the new base with length 0.
- rst_n asserted low mid-cycle while a 3-beat burst is pending -> state cleared immediately, no emit, burst_count=0. After release, a fresh burst is detected correctly.

Source files
------------

// File: rtl/detect_burst_paged.sv
// Merges a stream of per-beat addresses into {length, base} burst tokens that never
// cross a page boundary; the length is also fanned out to several length FIFOs.
module detect_burst_paged #(
  parameter int AddrWidth         = 64,
  parameter int DataWidthBytesLog = 6,
  parameter int PageBytesLog      = 12,
  parameter int WaitTimeWidth     = 4,
  parameter int BurstLenWidth     = 8,
  parameter int NumLenPorts       = 2,
  parameter int CountWidth        = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [WaitTimeWidth-1:0]           max_wait_time,
  input  logic [BurstLenWidth-1:0]           max_burst_len,
  input  logic                               flush,
  input  logic [AddrWidth-1:0]               addr_dout,
  input  logic                               addr_empty_n,
  output logic                               addr_read,
  output logic [BurstLenWidth+AddrWidth-1:0] addr_din,
  input  logic                               addr_full_n,
  output logic                               addr_write,
  output logic [NumLenPorts*BurstLenWidth-1:0] burst_len_din,
  input  logic [NumLenPorts-1:0]             burst_len_full_n,
  output logic [NumLenPorts-1:0]             burst_len_write,
  output logic [CountWidth-1:0]              burst_count
);

  localparam int BeatWidth = AddrWidth - DataWidthBytesLog;

  logic [AddrWidth-1:0]     base_addr, base_addr_next;
  logic                     base_valid, base_valid_next;
  logic [BurstLenWidth-1:0] burst_len, burst_len_next;
  logic [WaitTimeWidth-1:0] wait_time, wait_time_next;
  logic [CountWidth-1:0]    count_next;
  logic                     ready, accept, merge, emit;
  logic [BeatWidth-1:0]     next_beat;

  assign ready  = addr_full_n & (&burst_len_full_n);
  assign accept = ready & addr_empty_n;

  // The beat that would extend the pending burst; low in-beat bits are ignored.
  assign next_beat = base_addr[AddrWidth-1:DataWidthBytesLog]
                   + BeatWidth'(burst_len) + BeatWidth'(1);

  assign merge = (addr_dout[AddrWidth-1:DataWidthBytesLog] == next_beat)
               & (burst_len < max_burst_len)
               & (addr_dout[AddrWidth-1:PageBytesLog] == base_addr[AddrWidth-1:PageBytesLog])
               & ~flush;

  assign addr_read       = accept;
  assign addr_write      = emit;
  assign burst_len_write = {NumLenPorts{emit}};
  assign addr_din        = {burst_len, base_addr};
  assign burst_len_din   = {NumLenPorts{burst_len}};

  always_comb begin
    base_addr_next  = base_addr;
    base_valid_next = base_valid;
    burst_len_next  = burst_len;
    wait_time_next  = wait_time;
    emit            = 1'b0;
    if (ready) begin
      if (accept) begin
        wait_time_next = '0;
        if (!base_valid) begin
          base_addr_next  = addr_dout;
          base_valid_next = 1'b1;
          burst_len_next  = '0;
        end else if (merge) begin
          burst_len_next = burst_len + BurstLenWidth'(1);
        end else begin
          // Emitted token is the pre-accept state; the new address starts the next burst.
          emit           = 1'b1;
          base_addr_next = addr_dout;
          burst_len_next = '0;
        end
      end else if (base_valid) begin
        if (!flush && (wait_time < max_wait_time)) begin
          wait_time_next = wait_time + WaitTimeWidth'(1);
        end else begin
          emit            = 1'b1;
          base_valid_next = 1'b0;
          burst_len_next  = '0;
          wait_time_next  = '0;
        end
      end
    end
  end

  always_comb begin
    count_next = burst_count;
    if (emit) count_next = burst_count + CountWidth'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_addr   <= '0;
      base_valid  <= 1'b0;
      burst_len   <= '0;
      wait_time   <= '0;
      burst_count <= '0;
    end else begin
      base_addr   <= base_addr_next;
      base_valid  <= base_valid_next;
      burst_len   <= burst_len_next;
      wait_time   <= wait_time_next;
      burst_count <= count_next;
    end
  end

endmodule

// File: tb/tb_detect_burst_paged.sv
// Scoreboard bench for detect_burst_paged: expected tokens are queued with the stimulus
// and a negedge monitor pops and compares each emitted token.
module tb_detect_burst_paged;

  localparam int AW = 64;
  localparam int BL = 8;
  localparam int WT = 4;
  localparam int NP = 2;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WT-1:0]    max_wait_time;
  logic [BL-1:0]    max_burst_len;
  logic             flush;
  logic [AW-1:0]    addr_dout;
  logic             addr_empty_n;
  logic             addr_read;
  logic [BL+AW-1:0] addr_din;
  logic             addr_full_n;
  logic             addr_write;
  logic [NP*BL-1:0] burst_len_din;
  logic [NP-1:0]    burst_len_full_n;
  logic [NP-1:0]    burst_len_write;
  logic [CW-1:0]    burst_count;

  always #5 clk = ~clk;

  detect_burst_paged dut (
    .clk(clk), .rst_n(rst_n), .max_wait_time(max_wait_time), .max_burst_len(max_burst_len),
    .flush(flush), .addr_dout(addr_dout), .addr_empty_n(addr_empty_n), .addr_read(addr_read),
    .addr_din(addr_din), .addr_full_n(addr_full_n), .addr_write(addr_write),
    .burst_len_din(burst_len_din), .burst_len_full_n(burst_len_full_n),
    .burst_len_write(burst_len_write), .burst_count(burst_count)
  );

  typedef struct {
    logic [BL-1:0] len;
    logic [AW-1:0] addr;
    logic [CW-1:0] count_before;
  } token_t;

  token_t        exp_q[$];
  int            errors = 0;
  int            checks = 0;
  logic [CW-1:0] push_count = '0;

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectBurst(input logic [BL-1:0] len, input logic [AW-1:0] addr);
    token_t t;
    t.len          = len;
    t.addr         = addr;
    t.count_before = push_count;
    exp_q.push_back(t);
    push_count++;
  endtask

  // Drive one input pattern for a number of cycles, then return to idle.
  task automatic applyStimulus(input logic valid, input logic [AW-1:0] a,
                               input logic fl, input int cycles);
    addr_empty_n = valid;
    addr_dout    = a;
    flush        = fl;
    repeat (cycles) @(posedge clk);
    #1;
    addr_empty_n = 1'b0;
    flush        = 1'b0;
  endtask

  // Any write must match the head of the scoreboard.
  initial begin : monitor
    token_t t;
    forever begin
      @(negedge clk);
      if (rst_n && (addr_write || (burst_len_write != '0))) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_emit: actual=0x%0h expected=no write", addr_din);
        end else begin
          t = exp_q.pop_front();
          checkOutput("emit_token", 128'(addr_din), 128'({t.len, t.addr}));
          for (int i = 0; i < NP; i++)
            checkOutput("emit_len_port", 128'(burst_len_din[i*BL +: BL]), 128'(t.len));
          checkOutput("emit_len_write", 128'(burst_len_write), 128'({NP{1'b1}}));
          checkOutput("emit_addr_write", 128'(addr_write), 128'(1'b1));
          checkOutput("count_before_emit", 128'(burst_count), 128'(t.count_before));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst_n            = 1'b0;
    max_wait_time    = 4'd3;
    max_burst_len    = 8'd255;
    flush            = 1'b0;
    addr_dout        = '0;
    addr_empty_n     = 1'b0;
    addr_full_n      = 1'b1;
    burst_len_full_n = 2'b11;
    #12;
    checkOutput("reset_addr_read", 128'(addr_read), 128'(0));
    checkOutput("reset_addr_write", 128'(addr_write), 128'(0));
    checkOutput("reset_len_write", 128'(burst_len_write), 128'(0));
    checkOutput("reset_addr_din", 128'(addr_din), 128'(0));
    checkOutput("reset_len_din", 128'(burst_len_din), 128'(0));
    checkOutput("reset_count", 128'(burst_count), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] contiguous burst with timeout");
    expectBurst(8'd3, 64'h0);
    applyStimulus(1'b1, 64'h0, 1'b0, 1);
    applyStimulus(1'b1, 64'h40, 1'b0, 1);
    applyStimulus(1'b1, 64'h80, 1'b0, 1);
    applyStimulus(1'b1, 64'hC0, 1'b0, 1);
    applyStimulus(1'b0, 64'h0, 1'b0, 3);
    checkOutput("t1_not_before_timeout", 128'(exp_q.size()), 128'(1));
    applyStimulus(1'b0, 64'h0, 1'b0, 1);
    checkOutput("t1_emitted_on_timeout", 128'(exp_q.size()), 128'(0));
    checkOutput("t1_count", 128'(burst_count), 128'(1));

    $display("[TB] page crossing");
    expectBurst(8'd1, 64'hF80);
    expectBurst(8'd1, 64'h1000);
    applyStimulus(1'b1, 64'hF80, 1'b0, 1);
    applyStimulus(1'b1, 64'hFC0, 1'b0, 1);
    applyStimulus(1'b1, 64'h1000, 1'b0, 1);
    checkOutput("t2_emit_on_break", 128'(exp_q.size()), 128'(1));
    applyStimulus(1'b1, 64'h1040, 1'b0, 1);
    applyStimulus(1'b0, 64'h0, 1'b0, 4);
    checkOutput("t2_emit_timeout", 128'(exp_q.size()), 128'(0));
    checkOutput("t2_count", 128'(burst_count), 128'(3));

    $display("[TB] max_burst_len limits");
    max_burst_len = 8'd1;
    expectBurst(8'd1, 64'h0);
    expectBurst(8'd0, 64'h80);
    applyStimulus(1'b1, 64'h0, 1'b0, 1);
    applyStimulus(1'b1, 64'h40, 1'b0, 1);
    applyStimulus(1'b1, 64'h80, 1'b0, 1);
    checkOutput("t3_len1_break", 128'(exp_q.size()), 128'(1));
    applyStimulus(1'b0, 64'h0, 1'b0, 4);
    checkOutput("t3_len1_done", 128'(exp_q.size()), 128'(0));
    max_burst_len = 8'd0;
    expectBurst(8'd0, 64'h0);
    expectBurst(8'd0, 64'h40);
    expectBurst(8'd0, 64'h80);
    applyStimulus(1'b1, 64'h0, 1'b0, 1);
    applyStimulus(1'b1, 64'h40, 1'b0, 1);
    applyStimulus(1'b1, 64'h80, 1'b0, 1);
    applyStimulus(1'b0, 64'h0, 1'b0, 4);
    checkOutput("t3_len0_done", 128'(exp_q.size()), 128'(0));
    checkOutput("t3_count", 128'(burst_count), 128'(8));
    max_burst_len = 8'd255;

    $display("[TB] backpressure holds state");
    applyStimulus(1'b1, 64'h100, 1'b0, 1);
    applyStimulus(1'b1, 64'h140, 1'b0, 1);
    applyStimulus(1'b1, 64'h180, 1'b0, 1);
    addr_empty_n     = 1'b1;
    addr_dout        = 64'h1C0;
    flush            = 1'b1;
    burst_len_full_n = 2'b01;
    for (int i = 0; i < 10; i++) begin
      #2;
      checkOutput("stall_addr_read", 128'(addr_read), 128'(0));
      checkOutput("stall_addr_write", 128'(addr_write), 128'(0));
      @(posedge clk);
      #1;
    end
    addr_empty_n     = 1'b0;
    flush            = 1'b0;
    burst_len_full_n = 2'b11;
    expectBurst(8'd2, 64'h100);
    applyStimulus(1'b0, 64'h0, 1'b0, 3);
    checkOutput("t4_not_before_timeout", 128'(exp_q.size()), 128'(1));
    applyStimulus(1'b0, 64'h0, 1'b0, 1);
    checkOutput("t4_emitted", 128'(exp_q.size()), 128'(0));
    checkOutput("t4_count", 128'(burst_count), 128'(9));

    $display("[TB] flush");
    applyStimulus(1'b1, 64'h200, 1'b0, 1);
    applyStimulus(1'b1, 64'h240, 1'b0, 1);
    expectBurst(8'd1, 64'h200);
    applyStimulus(1'b0, 64'h0, 1'b1, 1);
    checkOutput("t5_flush_idle", 128'(exp_q.size()), 128'(0));
    applyStimulus(1'b1, 64'h200, 1'b0, 1);
    applyStimulus(1'b1, 64'h240, 1'b0, 1);
    expectBurst(8'd1, 64'h200);
    applyStimulus(1'b1, 64'h240, 1'b1, 1);
    checkOutput("t5_flush_accept", 128'(exp_q.size()), 128'(0));
    expectBurst(8'd0, 64'h240);
    applyStimulus(1'b0, 64'h0, 1'b0, 4);
    checkOutput("t5_new_base_done", 128'(exp_q.size()), 128'(0));
    checkOutput("t5_count", 128'(burst_count), 128'(12));

    $display("[TB] reset mid-burst");
    applyStimulus(1'b1, 64'h300, 1'b0, 1);
    applyStimulus(1'b1, 64'h340, 1'b0, 1);
    applyStimulus(1'b1, 64'h380, 1'b0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    push_count = '0;
    checkOutput("midrst_addr_write", 128'(addr_write), 128'(0));
    checkOutput("midrst_addr_din", 128'(addr_din), 128'(0));
    checkOutput("midrst_len_din", 128'(burst_len_din), 128'(0));
    checkOutput("midrst_count", 128'(burst_count), 128'(0));
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expectBurst(8'd1, 64'h400);
    applyStimulus(1'b1, 64'h400, 1'b0, 1);
    applyStimulus(1'b1, 64'h440, 1'b0, 1);
    applyStimulus(1'b0, 64'h0, 1'b0, 3);
    checkOutput("t6_not_before_timeout", 128'(exp_q.size()), 128'(1));
    applyStimulus(1'b0, 64'h0, 1'b0, 1);
    checkOutput("t6_emitted", 128'(exp_q.size()), 128'(0));
    checkOutput("t6_count", 128'(burst_count), 128'(1));

    applyStimulus(1'b0, 64'h0, 1'b0, 3);
    checkOutput("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
